cdb_arbiter: RTL and testbench

Arbiter and buffer for the single common data bus (CDB) that broadcasts completed results to the reservation station, load/store buffer and ROB. It accepts results from two producers, the ALU and the memory unit, and queues each stream in a small per-source FIFO. It grants the bus round-robin at one result per cycle and drives a registered broadcast. It replaces direct wiring of the two `*_valid/value/dependency` pairs into every consumer, so consumers see at most one result per cycle.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_result_fifo.sv | 59 +++++
 rtl/cdb_arbiter.sv | 129 ++++++++++++
 tb/tb_cdb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus: ROB tag width, the
// "no dependency" tag encoding, and the CDB source identifiers.
// No ports; imported by cdb_arbiter and result_fifo.
package const_param;

  // ROB index width; dependency tags carry one extra bit.
  localparam int ROB_SIZE_WIDTH = 3;

  // All-ones tag means "no dependency" (default tag width).
  localparam logic [ROB_SIZE_WIDTH:0] NO_DEP_TAG = '1;

  // Source identifiers driven on cdb_src.
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_MEM = 1'b1;

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Synchronous FIFO with head peek, push, pop, flush and occupancy count.
// Ports: clk/rst_n, en (global freeze when low), flush, push/push_data,
//        pop, head (current oldest entry), count (0..DEPTH).
module result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH):0]       count
);
  import const_param::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  // Pointers are exactly log2(DEPTH) bits, so they wrap with no compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage needs no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (en && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and per-source buffering for the common data bus.
// Ports: clk_in/rst_n_in, rdy_in freeze, need_flush_in; ALU and MEM
//        valid/value/tag/ready request ports; registered cdb_* broadcast.
module cdb_arbiter #(
  parameter int ROB_SIZE_WIDTH = const_param::ROB_SIZE_WIDTH,
  parameter int QDEPTH         = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      alu_req_valid,
  input  logic [31:0]               alu_req_value,
  input  logic [ROB_SIZE_WIDTH:0]   alu_req_tag,
  output logic                      alu_req_ready,
  input  logic                      mem_req_valid,
  input  logic [31:0]               mem_req_value,
  input  logic [ROB_SIZE_WIDTH:0]   mem_req_tag,
  output logic                      mem_req_ready,
  output logic                      cdb_valid,
  output logic [31:0]               cdb_value,
  output logic [ROB_SIZE_WIDTH:0]   cdb_dependency,
  output logic                      cdb_src
);
  import const_param::*;

  localparam int TW = ROB_SIZE_WIDTH + 1;
  localparam int DW = 32 + TW;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  // FIFO interface signals
  logic [DW-1:0] alu_head, mem_head;
  logic [CW-1:0] alu_cnt, mem_cnt;
  logic          alu_push, alu_pop, mem_push, mem_pop;

  // Arbitration signals
  logic          active;
  logic          alu_acc, mem_acc;
  logic          alu_has, mem_has;
  logic          alu_cand_vld, mem_cand_vld;
  logic [DW-1:0] alu_cand, mem_cand;
  logic          grant_vld, grant_src;
  logic [DW-1:0] grant_dat;
  logic          alu_grant, mem_grant;
  logic          last_grant;

  result_fifo #(.WIDTH(DW), .DEPTH(QDEPTH)) u_alu_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .en        (rdy_in),
    .flush     (need_flush_in),
    .push      (alu_push),
    .push_data ({alu_req_value, alu_req_tag}),
    .pop       (alu_pop),
    .head      (alu_head),
    .count     (alu_cnt)
  );

  result_fifo #(.WIDTH(DW), .DEPTH(QDEPTH)) u_mem_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .en        (rdy_in),
    .flush     (need_flush_in),
    .push      (mem_push),
    .push_data ({mem_req_value, mem_req_tag}),
    .pop       (mem_pop),
    .head      (mem_head),
    .count     (mem_cnt)
  );

  // Ready depends only on occupancy, never on the request valid.
  assign active        = rdy_in & ~need_flush_in;
  assign alu_req_ready = active & (alu_cnt != FULL);
  assign mem_req_ready = active & (mem_cnt != FULL);
  assign alu_acc       = alu_req_valid & alu_req_ready;
  assign mem_acc       = mem_req_valid & mem_req_ready;

  always_comb begin
    alu_has      = (alu_cnt != '0);
    mem_has      = (mem_cnt != '0);
    // A queued result always precedes a new request from the same source.
    alu_cand_vld = active & (alu_has | alu_acc);
    mem_cand_vld = active & (mem_has | mem_acc);
    alu_cand     = alu_has ? alu_head : {alu_req_value, alu_req_tag};
    mem_cand     = mem_has ? mem_head : {mem_req_value, mem_req_tag};

    grant_vld = alu_cand_vld | mem_cand_vld;
    grant_src = CDB_SRC_ALU;
    if (alu_cand_vld && mem_cand_vld) grant_src = ~last_grant;
    else if (mem_cand_vld)            grant_src = CDB_SRC_MEM;
    grant_dat = (grant_src == CDB_SRC_MEM) ? mem_cand : alu_cand;

    alu_grant = grant_vld & (grant_src == CDB_SRC_ALU);
    mem_grant = grant_vld & (grant_src == CDB_SRC_MEM);

    // Pop only when the head went out; push when the accepted request
    // was not itself bypassed onto the bus this cycle.
    alu_pop  = alu_grant & alu_has;
    mem_pop  = mem_grant & mem_has;
    alu_push = alu_acc & ~(alu_grant & ~alu_has);
    mem_push = mem_acc & ~(mem_grant & ~mem_has);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid      <= 1'b0;
      cdb_value      <= '0;
      cdb_dependency <= '1;
      cdb_src        <= CDB_SRC_ALU;
      last_grant     <= CDB_SRC_MEM;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        cdb_valid  <= 1'b0;
        last_grant <= CDB_SRC_MEM;  // ALU wins the first tie after a flush
      end else if (grant_vld) begin
        cdb_valid      <= 1'b1;
        cdb_value      <= grant_dat[DW-1:TW];
        cdb_dependency <= grant_dat[TW-1:0];
        cdb_src        <= grant_src;
        last_grant     <= grant_src;
      end else begin
        // Payload fields hold; only valid drops.
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        need_flush_in = 1'b0;
  logic        alu_req_valid = 1'b0;
  logic [31:0] alu_req_value = '0;
  logic [3:0]  alu_req_tag = '0;
  logic        alu_req_ready;
  logic        mem_req_valid = 1'b0;
  logic [31:0] mem_req_value = '0;
  logic [3:0]  mem_req_tag = '0;
  logic        mem_req_ready;
  logic        cdb_valid;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_dependency;
  logic        cdb_src;

  cdb_arbiter #(.ROB_SIZE_WIDTH(3), .QDEPTH(2)) u_dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .need_flush_in  (need_flush_in),
    .alu_req_valid  (alu_req_valid),
    .alu_req_value  (alu_req_value),
    .alu_req_tag    (alu_req_tag),
    .alu_req_ready  (alu_req_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_value  (mem_req_value),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .cdb_valid      (cdb_valid),
    .cdb_value      (cdb_value),
    .cdb_dependency (cdb_dependency),
    .cdb_src        (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        src;
    logic [31:0] val;
    logic [3:0]  tag;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  logic rdy_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic src, input logic [31:0] val, input logic [3:0] tag);
    exp_t e;
    e.src = src;
    e.val = val;
    e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    alu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    need_flush_in = 1'b0;
    rdy_in        = 1'b1;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    expq.delete();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, expq.size(), 0);
    tick();
    tick();
  endtask

  // Whether the edge that produced the current outputs was an active one.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rdy_q <= 1'b0;
    else           rdy_q <= rdy_in;
  end

  // Monitor: every fresh broadcast must match the head of the expected queue.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n_in && rdy_q && cdb_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL cdb_unexpected: got src=%0d val=%0h tag=%0h expected none",
                 cdb_src, cdb_value, cdb_dependency);
      end else begin
        e = expq.pop_front();
        chk("cdb_src", {31'd0, cdb_src}, {31'd0, e.src});
        chk("cdb_value", cdb_value, e.val);
        chk("cdb_tag", {28'd0, cdb_dependency}, {28'd0, e.tag});
      end
    end
  end

  initial begin
    bit ra_tab[9];
    bit rm_tab[9];
    int ia, im;
    logic acca, accm;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, cdb_valid}, 0);
    chk("rst_value", cdb_value, 0);
    chk("rst_tag", {28'd0, cdb_dependency}, 32'hF);
    chk("rst_src", {31'd0, cdb_src}, 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    // Single ALU request, bypassed in one cycle
    alu_req_valid = 1'b1;
    alu_req_value = 32'h1234;
    alu_req_tag   = 4'd3;
    push_exp(1'b0, 32'h1234, 4'd3);
    tick();
    alu_req_valid = 1'b0;
    chk("single_alu_cnt", {30'd0, u_dut.alu_cnt}, 0);
    tick();
    chk("single_pulse_low", {31'd0, cdb_valid}, 0);
    drain("single");

    // Simultaneous pair after reset: ALU first, MEM queued one cycle
    do_reset();
    alu_req_valid = 1'b1; alu_req_value = 32'hA; alu_req_tag = 4'd1;
    mem_req_valid = 1'b1; mem_req_value = 32'hB; mem_req_tag = 4'd2;
    push_exp(1'b0, 32'hA, 4'd1);
    push_exp(1'b1, 32'hB, 4'd2);
    tick();
    alu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    chk("pair_mem_cnt1", {30'd0, u_dut.mem_cnt}, 1);
    tick();
    chk("pair_mem_cnt0", {30'd0, u_dut.mem_cnt}, 0);
    drain("pair");

    // Continuous contention: strict alternation, ready drops when full
    do_reset();
    ra_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rm_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      push_exp(1'b0, 32'h100 + 32'(i), 4'(i));
      push_exp(1'b1, 32'h200 + 32'(i), 4'(8 + i));
    end
    ia = 0;
    im = 0;
    for (int c = 0; c < 9; c++) begin
      alu_req_valid = (ia < 6);
      alu_req_value = 32'h100 + 32'(ia);
      alu_req_tag   = 4'(ia);
      mem_req_valid = (im < 6);
      mem_req_value = 32'h200 + 32'(im);
      mem_req_tag   = 4'(8 + im);
      @(negedge clk_in);
      chk($sformatf("cont_alu_ready_c%0d", c), {31'd0, alu_req_ready}, {31'd0, ra_tab[c]});
      chk($sformatf("cont_mem_ready_c%0d", c), {31'd0, mem_req_ready}, {31'd0, rm_tab[c]});
      acca = alu_req_valid & alu_req_ready;
      accm = mem_req_valid & mem_req_ready;
      tick();
      ia += int'(acca);
      im += int'(accm);
    end
    alu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    drain("contention");

    // Flush with two MEM results queued
    do_reset();
    push_exp(1'b0, 32'h300, 4'd1);
    push_exp(1'b1, 32'h400, 4'd9);
    push_exp(1'b0, 32'h301, 4'd2);
    for (int c = 0; c < 3; c++) begin
      alu_req_valid = 1'b1; alu_req_value = 32'h300 + 32'(c); alu_req_tag = 4'(1 + c);
      mem_req_valid = 1'b1; mem_req_value = 32'h400 + 32'(c); mem_req_tag = 4'(9 + c);
      tick();
    end
    alu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    chk("flush_pre_mem_cnt", {30'd0, u_dut.mem_cnt}, 2);
    chk("flush_pre_alu_cnt", {30'd0, u_dut.alu_cnt}, 1);
    need_flush_in = 1'b1;
    tick();
    need_flush_in = 1'b0;
    chk("flush_valid", {31'd0, cdb_valid}, 0);
    chk("flush_mem_cnt", {30'd0, u_dut.mem_cnt}, 0);
    chk("flush_alu_cnt", {30'd0, u_dut.alu_cnt}, 0);
    alu_req_valid = 1'b1; alu_req_value = 32'h310; alu_req_tag = 4'd5;
    mem_req_valid = 1'b1; mem_req_value = 32'h410; mem_req_tag = 4'd12;
    push_exp(1'b0, 32'h310, 4'd5);
    push_exp(1'b1, 32'h410, 4'd12);
    tick();
    alu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    drain("flush");

    // Freeze with one entry in each FIFO
    do_reset();
    push_exp(1'b0, 32'h500, 4'd1);
    push_exp(1'b1, 32'h600, 4'd9);
    push_exp(1'b0, 32'h501, 4'd2);
    push_exp(1'b1, 32'h601, 4'd10);
    for (int c = 0; c < 2; c++) begin
      alu_req_valid = 1'b1; alu_req_value = 32'h500 + 32'(c); alu_req_tag = 4'(1 + c);
      mem_req_valid = 1'b1; mem_req_value = 32'h600 + 32'(c); mem_req_tag = 4'(9 + c);
      tick();
    end
    alu_req_valid = 1'b0;
    mem_req_valid = 1'b0;
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("frz_valid_c%0d", c), {31'd0, cdb_valid}, 1);
      chk($sformatf("frz_value_c%0d", c), cdb_value, 32'h600);
      chk($sformatf("frz_tag_c%0d", c), {28'd0, cdb_dependency}, 9);
      chk($sformatf("frz_alu_cnt_c%0d", c), {30'd0, u_dut.alu_cnt}, 1);
      chk($sformatf("frz_mem_cnt_c%0d", c), {30'd0, u_dut.mem_cnt}, 1);
    end
    rdy_in = 1'b1;
    drain("freeze");

    // Asynchronous reset while a broadcast is on the bus
    do_reset();
    alu_req_valid = 1'b1; alu_req_value = 32'h777; alu_req_tag = 4'd4;
    tick();
    alu_req_valid = 1'b0;
    chk("arst_pre_valid", {31'd0, cdb_valid}, 1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("arst_valid", {31'd0, cdb_valid}, 0);
    chk("arst_tag", {28'd0, cdb_dependency}, 32'hF);
    chk("arst_value", cdb_value, 0);
    chk("arst_src", {31'd0, cdb_src}, 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
